// File: rtl/dvs_fifo_bus_arbiter.sv
// Round-robin arbiter that hands a shared FIFO event-queue bus to one requester for a
// fixed tenure. Writers are gated by fifo_full and readers by fifo_empty.
module dvs_fifo_bus_arbiter #(
    parameter int                 NUM_REQ       = 2,
    parameter int                 TENURE_CYCLES = 2,
    parameter logic [NUM_REQ-1:0] WRITER_MASK   = NUM_REQ'(1),
    localparam int                ID_W          = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TENURE_CYCLES < 1 || TENURE_CYCLES > 15) begin : g_bad_tenure
        $error("TENURE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         count;
    logic [ID_W-1:0]    last_id;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;
    logic [NUM_REQ-1:0] eligible;
    logic               any_eligible;

    // Illegal full&empty together makes every requester ineligible on its own.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req[i] && (WRITER_MASK[i] ? !fifo_full : !fifo_empty);
        end
    end

    // NOTE: every variable gets a default at the top of always_comb; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        winner       = last_id;
        any_eligible = 1'b0;
        idx          = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((int'(last_id) + off) % NUM_REQ);
            if (!any_eligible && eligible[idx]) begin
                any_eligible = 1'b1;
                winner       = idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_eligible) state_next = GRANT;
            GRANT:   state_next = HOLD;
            HOLD:    if (count <= 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= 4'd0;
            last_id <= ID_W'(NUM_REQ - 1);
            grant   <= '0;
        end else begin
            state <= state_next;
            grant <= '0;
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        grant   <= NUM_REQ'(1) << winner;
                        last_id <= winner;
                    end
                end
                GRANT: count <= 4'(TENURE_CYCLES);
                HOLD:  if (count != 4'd0) count <= count - 4'd1;
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign grant_id = last_id;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_grant_busy:   assert property (@(posedge clk) disable iff (!rst_n) (grant != '0) |-> busy);

endmodule

// File: tb/tb_dvs_fifo_bus_arbiter.sv
// Bench for dvs_fifo_bus_arbiter: a default 2-requester instance and a 4-requester
// instance share fifo flags and reset, and both are checked every cycle against a model.
module tb_dvs_fifo_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] req_a;
    logic [3:0] req_b;
    logic [1:0] grant_a;
    logic       grant_id_a;
    logic       busy_a;
    logic [3:0] grant_b;
    logic [1:0] grant_id_b;
    logic       busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: busy cycles still to come (including one idle gap), last winner.
    int         rem[2];
    int         last[2];
    logic [7:0] exp_grant[2];
    logic       exp_busy[2];

    always #5 clk = ~clk;

    dvs_fifo_bus_arbiter dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_a),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .grant      (grant_a),
        .grant_id   (grant_id_a),
        .busy       (busy_a)
    );

    dvs_fifo_bus_arbiter #(
        .NUM_REQ       (4),
        .TENURE_CYCLES (1),
        .WRITER_MASK   (4'b0011)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_b),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .grant      (grant_b),
        .grant_id   (grant_id_b),
        .busy       (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model of instance k across one rising edge using the inputs seen there.
    task automatic model_step(input int k, input int n, input int t,
                              input logic [7:0] mask, input logic [7:0] r);
        int w;
        if (!rst_n) begin
            rem[k] = 0; last[k] = n - 1; exp_grant[k] = '0; exp_busy[k] = 1'b0;
            return;
        end
        exp_grant[k] = '0;
        if (rem[k] > 0) begin
            rem[k]--;
            exp_busy[k] = (rem[k] > 0);
            return;
        end
        w = -1;
        for (int off = 1; off <= n; off++) begin
            int i;
            i = (last[k] + off) % n;
            if (w < 0 && r[i] && (mask[i] ? !fifo_full : !fifo_empty)) w = i;
        end
        if (w >= 0) begin
            exp_grant[k] = 8'(1) << w;
            exp_busy[k]  = 1'b1;
            last[k]      = w;
            rem[k]       = t + 1;
        end else begin
            exp_busy[k] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 2, 2, 8'b0000_0001, {6'b0, req_a});
        model_step(1, 4, 1, 8'b0000_0011, {4'b0, req_b});
        #1;
        check("a_grant",    32'(grant_a),    32'(exp_grant[0]));
        check("a_busy",     32'(busy_a),     32'(exp_busy[0]));
        check("a_grant_id", 32'(grant_id_a), 32'(last[0]));
        check("b_grant",    32'(grant_b),    32'(exp_grant[1]));
        check("b_busy",     32'(busy_b),     32'(exp_busy[1]));
        check("b_grant_id", 32'(grant_id_b), 32'(last[1]));
    endtask

    initial begin
        rst_n = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0; req_a = 2'b11; req_b = 4'b1111;
        #1;
        repeat (3) cycle();
        check("rst_grant_id_a", 32'(grant_id_a), 32'd1);
        check("rst_grant_id_b", 32'(grant_id_b), 32'd3);

        // Both requesters always eligible from release: fixed grant schedule.
        rst_n = 1'b1;
        for (int j = 1; j <= 13; j++) begin
            cycle();
            check("sched_a_grant", 32'(grant_a),
                  (j % 4 == 1) ? (((j / 4) % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
            check("sched_a_busy", 32'(busy_a), (j % 4 != 0) ? 32'd1 : 32'd0);
            check("sched_b_grant", 32'(grant_b),
                  (j % 3 == 1) ? (32'd1 << ((j / 3) % 4)) : 32'd0);
        end

        // Empty queue: only the writer (requester 0) may be granted.
        fifo_empty = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cycle();
            check("empty_no_reader", 32'(grant_a[1]), 32'd0);
        end

        // Full queue blocks the lone writer until it drains.
        fifo_empty = 1'b0; fifo_full = 1'b1; req_a = 2'b01;
        repeat (4) cycle();
        for (int j = 0; j < 10; j++) begin
            cycle();
            check("full_idle_busy", 32'(busy_a), 32'd0);
        end
        fifo_full = 1'b0;
        cycle();
        check("full_release_grant", 32'(grant_a), 32'd1);

        // A reset pulse between edges must not be seen.
        req_a = 2'b11;
        cycle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (3) cycle();

        // Random traffic with occasional resets, illegal flags and glitches.
        for (int j = 0; j < 3000; j++) begin
            req_a      = 2'($urandom);
            req_b      = 4'($urandom);
            fifo_full  = ($urandom_range(0, 3) == 0);
            fifo_empty = ($urandom_range(0, 3) == 0);
            rst_n      = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
